// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle for the shared seven-segment display arbiter.
// The blank line exists only when SEG_ARB_BLANK_EN is defined.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [2:0]  gnt;
  logic [15:0] bigbin;
  logic        scan_tick;
`ifdef SEG_ARB_BLANK_EN
  logic        blank;

  modport master (output req, data0, data1, data2,
                  input  gnt, bigbin, scan_tick, blank);
  modport slave  (input  req, data0, data1, data2,
                  output gnt, bigbin, scan_tick, blank);
`else
  modport master (output req, data0, data1, data2,
                  input  gnt, bigbin, scan_tick);
  modport slave  (input  req, data0, data1, data2,
                  output gnt, bigbin, scan_tick);
`endif
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority display arbiter with minimum ownership time and scan-tick divider.
// Optional blank output compiled in with SEG_ARB_BLANK_EN.
module seg_display_arbiter #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int HOLD_TICKS = 500
) (
  input  logic               clk,
  input  logic               rst,
  seg_display_arbiter_if.slave bus
);

  localparam int DIV    = CLK_HZ / SCAN_HZ;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_OPEN} state_e;

  state_e              state_q, state_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [15:0]         bigbin_q, bigbin_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DIV_W-1:0]    div_q;
  logic                tick;
  logic [2:0][15:0]    data_a;
  logic [2:0]          win;
  logic [15:0]         win_data, own_data;
  logic                own_req;

  function automatic logic [2:0] prio_oh(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  // Free-running divider; never disturbed by arbitration.
  always_ff @(posedge clk) begin
    if (rst)                  div_q <= '0;
    else if (div_q == DIV_LAST) div_q <= '0;
    else                      div_q <= div_q + 1'b1;
  end

  assign tick = (div_q == DIV_LAST);

  assign data_a  = {bus.data2, bus.data1, bus.data0};
  assign win     = prio_oh(bus.req);
  assign own_req = |(bus.req & gnt_q);

  always_comb begin
    win_data = '0;
    own_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (win[i])   win_data = win_data | data_a[i];
      if (gnt_q[i]) own_data = own_data | data_a[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    bigbin_d = bigbin_q;
    hold_d   = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|win) begin
          gnt_d    = win;
          bigbin_d = win_data;
          hold_d   = HOLD_LD;
          state_d  = S_LOCKED;
        end else begin
          gnt_d    = '0;
          bigbin_d = '0;
        end
      end
      S_LOCKED: begin
        // A dropped owner keeps the grant; the display freezes on its last value.
        if (own_req) bigbin_d = own_data;
        if (tick && hold_q != '0) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HOLD_W'(1)) state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        if (win == 3'b000) begin
          gnt_d    = '0;
          bigbin_d = '0;
          state_d  = S_IDLE;
        end else if (win != gnt_q) begin
          gnt_d    = win;
          bigbin_d = win_data;
          hold_d   = HOLD_LD;
          state_d  = S_LOCKED;
        end else begin
          bigbin_d = own_data;
        end
      end
      default: begin
        gnt_d    = '0;
        bigbin_d = '0;
        hold_d   = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      bigbin_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      bigbin_q <= bigbin_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bigbin    = bigbin_q;
  assign bus.scan_tick = tick;

`ifdef SEG_ARB_BLANK_EN
  logic blank_q, blank_d;

  // Derived from the next state so blank lines up with gnt/bigbin.
  always_comb begin
    blank_d = (state_d == S_IDLE) ||
              ((state_d == S_LOCKED) && !(|(bus.req & gnt_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) blank_q <= 1'b1;
    else     blank_q <= blank_d;
  end

  assign bus.blank = blank_q;
`endif

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the 4-digit seven-segment display between three requesters (score, status message, debug) and generates the digit-scan enable. Sits upstream of the digit-scan multiplexer. Drives its 16-bit `bigbin` value and a one-cycle scan pulse, and returns a one-hot grant to the requesters. Fixed priority plus a minimum ownership time keeps the display from flickering between sources.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `SCAN_HZ`, 1000: digit-scan pulse rate.
- `HOLD_TICKS`, 500: minimum ownership in scan pulses before preemption or release (≥1).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  3  request per source; `req[2]` status message (highest), `req[1]` score, `req[0]` debug (lowest).
- `data0`, `data1`, `data2`  in  16 each  value to display for the corresponding source.
- `gnt`  out  3  one-hot owner; all zero when idle.
- `bigbin`  out  16  value for the digit-scan multiplexer.
- `scan_tick`  out  1  one-`clk` pulse at `SCAN_HZ`; clocks/enables the scanner.
- `blank`  out  1  present only with `SEG_ARB_BLANK_EN`.

## Operation
- Divider:
  - `DIV = CLK_HZ/SCAN_HZ` (integer division, ≥2).
  - Counter runs 0..DIV-1 and wraps.
  - `scan_tick`=1 exactly in the cycle the counter equals DIV-1.
  - Free-running; independent of arbitration.
- States: IDLE, LOCKED, OPEN.
- IDLE:
  - `gnt`=0, `bigbin`=16'h0000.
  - If any `req`, grant the highest-priority requester and go to LOCKED.
- LOCKED:
  - Loading: `hold_cnt` is loaded with HOLD_TICKS at the grant edge.
  - Countdown: `hold_cnt` decrements on each `scan_tick` while nonzero.
  - No preemption.
  - `bigbin` tracks the owner's `data` each cycle while the owner's `req`=1.
  - If the owner drops `req`, `bigbin` freezes at its last value and `gnt` stays asserted.
  - Go to OPEN when `hold_cnt` reaches 0.
- OPEN (re-evaluated every cycle):
  - Compute the highest-priority pending request.
  - None pending: go to IDLE.
  - Winner differs from owner: switch `gnt` to the winner, reload `hold_cnt`, go to LOCKED.
  - Winner is the owner: stay in OPEN and track the owner's `data`.
- Simultaneous requests always resolve by fixed priority 2 > 1 > 0.
- Requests never queue; a requester must hold `req` until granted.
- `gnt` is always one-hot or zero.

## Timing
- Reset values:
  - `gnt`=3'b000, `bigbin`=16'h0000, `scan_tick`=0.
  - Divider count=0, `hold_cnt`=0, state IDLE.
  - `blank`=1 (when compiled in).
- Reset mid-operation: all of the above take effect at the first edge with `rst`=1; the divider restarts from 0.
- Arbitration latency:
  - A `req` sampled at edge N produces `gnt` and the matching `bigbin` after edge N.
  - Both update together, with no cycle of mismatch.
- Data tracking: `data` sampled at edge N appears on `bigbin` after edge N (one register stage).
- Hold duration: ownership lasts between HOLD_TICKS−1 and HOLD_TICKS full scan periods, depending on divider phase at grant.
- LOCKED→OPEN: the transition occurs on the same edge where `hold_cnt` decrements 1→0.
- Preemption or release in OPEN takes one further edge.
- `scan_tick` period is exactly DIV cycles, including across grant changes.

## Configuration
- `SEG_ARB_BLANK_EN` defined:
  - `blank` port exists.
  - `blank`=1 in IDLE and while a LOCKED owner has dropped `req`; otherwise 0.
  - Registered with the same latency as `gnt`.
  - The scanner uses `blank` to drive all anodes inactive (4'b1111).
- Not defined:
  - No `blank` port.
  - IDLE shows 16'h0000 and a dropped owner shows its frozen value.

## Test plan
Bench parameters: CLK_HZ=8, SCAN_HZ=1 (DIV=8), HOLD_TICKS=2.
- Reset then idle 20 cycles:
  - `scan_tick` high at cycles 7 and 15 only.
  - `gnt`=0, `bigbin`=0, `blank`=1.
- `req`=3'b011 with data0=16'h000D and data1=16'h0123:
  - Next cycle `gnt`=3'b010, `bigbin`=16'h0123.
  - Change data1 to 16'h0124; `bigbin`=16'h0124 one cycle later.
- Owner 1 locked, then raise `req[2]` (data2=16'hDEAD) immediately:
  - `gnt` stays 3'b010 until `hold_cnt`=0.
  - One edge later `gnt`=3'b100, `bigbin`=16'hDEAD.
- Owner drops `req` while LOCKED:
  - `bigbin` frozen, `gnt` held, `blank`=1.
  - After hold expiry with no requests, IDLE with `gnt`=0, `bigbin`=0.
- Assert `rst` for one cycle mid-LOCKED:
  - All outputs and the divider return to reset values.
  - The next `scan_tick` comes 8 cycles after reset release.
